// File: rtl/econet_pkg.sv
// Shared constants for the Econet receive path: flag pattern, CRC-16/CCITT
// parameters and the receiver state encoding.
package econet_pkg;

    localparam logic [7:0]  FLAG     = 8'h7E;
    localparam logic [15:0] CRC_POLY = 16'h8408;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] FCS_GOOD = 16'hF0B8;

    localparam logic [1:0]  ST_HUNT  = 2'd0;
    localparam logic [1:0]  ST_FLAG  = 2'd1;
    localparam logic [1:0]  ST_DATA  = 2'd2;

endpackage

// File: rtl/econet_crc16_byte.sv
// One byte of reflected CRC-16/CCITT, consuming the data byte LSB first.
module econet_crc16_byte
    import econet_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_out[0] ^ byte_in[i])
                crc_out = (crc_out >> 1) ^ CRC_POLY;
            else
                crc_out = crc_out >> 1;
        end
    end

endmodule

// File: rtl/econet_rx.sv
// Bit-serial HDLC receiver for the Econet line: flag hunting, zero-bit
// removal, LSB-first byte assembly and running FCS accumulation.
module econet_rx
    import econet_pkg::*;
(
    input  logic        econet_clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        inhibit,
    output logic [7:0]  rx_byte,
    output logic [15:0] rx_fcs,
    output logic        rx_byte_ready,
    output logic        rx_frame_start,
    output logic        rx_frame_end,
    output logic        receiving
);

    logic [2:0]  ones_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic [7:0]  shift_next;
    logic        data_bit;
    logic        flag_det;
    logic        abort_det;
    logic        byte_done;
    logic        byte_done_q;
    logic [7:0]  byte_q;
    logic        deliver_q;
    logic [1:0]  state;
    logic [15:0] crc_next;

    // The bit on the line is classified by the run of 1s preceding it:
    // a 0 after five 1s is stuffing, and the sixth 1 is never data.
    always_comb begin
        data_bit   = (ones_cnt < 3'd5);
        flag_det   = !rx && (ones_cnt == 3'd6);
        abort_det  = rx && (ones_cnt >= 3'd6);
        shift_next = {rx, shift_reg[7:1]};
        byte_done  = data_bit && (bit_cnt == 3'd7);
    end

    always_ff @(posedge econet_clk or posedge reset) begin
        if (reset) begin
            ones_cnt    <= 3'd0;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'h00;
            byte_done_q <= 1'b0;
            byte_q      <= 8'h00;
        end else begin
            if (!rx)
                ones_cnt <= 3'd0;
            else if (ones_cnt != 3'd7)
                ones_cnt <= ones_cnt + 3'd1;

            byte_done_q <= byte_done;

            if (flag_det) begin
                bit_cnt <= 3'd0;
            end else if (data_bit) begin
                shift_reg <= shift_next;
                bit_cnt   <= bit_cnt + 3'd1;
                if (byte_done)
                    byte_q <= shift_next;
            end
        end
    end

    econet_crc16_byte u_crc (
        .crc_in  (rx_fcs),
        .byte_in (byte_q),
        .crc_out (crc_next)
    );

    // The CRC is held through the rx_frame_end cycle and re-preset just after,
    // so the closing flag can double as the next frame's opening flag.
    always_ff @(posedge econet_clk or posedge reset) begin
        if (reset) begin
            state          <= ST_HUNT;
            rx_fcs         <= 16'h0000;
            rx_frame_start <= 1'b0;
            rx_frame_end   <= 1'b0;
            receiving      <= 1'b0;
            deliver_q      <= 1'b0;
        end else begin
            rx_frame_start <= 1'b0;
            rx_frame_end   <= 1'b0;
            deliver_q      <= 1'b0;
            if (inhibit) begin
                state     <= ST_HUNT;
                receiving <= 1'b0;
            end else begin
                case (state)
                    ST_HUNT: begin
                        if (flag_det) begin
                            state  <= ST_FLAG;
                            rx_fcs <= CRC_INIT;
                        end
                    end
                    ST_FLAG: begin
                        if (abort_det) begin
                            state     <= ST_HUNT;
                            receiving <= 1'b0;
                        end else if (byte_done_q) begin
                            state          <= ST_DATA;
                            rx_frame_start <= 1'b1;
                            receiving      <= 1'b1;
                            deliver_q      <= 1'b1;
                            rx_fcs         <= crc_next;
                        end else if (rx_frame_end) begin
                            receiving <= 1'b0;
                            rx_fcs    <= CRC_INIT;
                        end
                    end
                    ST_DATA: begin
                        if (abort_det) begin
                            state     <= ST_HUNT;
                            receiving <= 1'b0;
                        end else if (flag_det) begin
                            state        <= ST_FLAG;
                            rx_frame_end <= 1'b1;
                        end else if (byte_done_q) begin
                            deliver_q <= 1'b1;
                            rx_fcs    <= crc_next;
                        end
                    end
                    default: begin
                        state     <= ST_HUNT;
                        receiving <= 1'b0;
                    end
                endcase
            end
        end
    end

    // byte_q stays stable for eight line bits, so it can feed the output here.
    always_ff @(posedge econet_clk or posedge reset) begin
        if (reset) begin
            rx_byte       <= 8'h00;
            rx_byte_ready <= 1'b0;
        end else begin
            rx_byte_ready <= deliver_q && !inhibit;
            if (deliver_q && !inhibit)
                rx_byte <= byte_q;
        end
    end

endmodule

// File: tb/tb_econet_rx.sv
// Scoreboard bench for econet_rx: frames are bit-stuffed onto rx, expected
// bytes and FCS values are queued as sent and popped when the DUT emits them.
module tb_econet_rx;

    typedef logic [7:0] byte_q_t [$];

    localparam logic [15:0] TB_FCS_GOOD = 16'hF0B8;

    logic        econet_clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        inhibit;
    logic [7:0]  rx_byte;
    logic [15:0] rx_fcs;
    logic        rx_byte_ready;
    logic        rx_frame_start;
    logic        rx_frame_end;
    logic        receiving;

    logic [7:0]  exp_bytes [$];
    logic [15:0] exp_fcs [$];
    int          checks = 0;
    int          passed = 0;
    int          start_cnt = 0;
    int          end_cnt = 0;
    int          tx_ones = 0;
    bit          await_first = 1'b0;
    bit          start_prev = 1'b0;

    econet_rx dut (
        .econet_clk     (econet_clk),
        .reset          (reset),
        .rx             (rx),
        .inhibit        (inhibit),
        .rx_byte        (rx_byte),
        .rx_fcs         (rx_fcs),
        .rx_byte_ready  (rx_byte_ready),
        .rx_frame_start (rx_frame_start),
        .rx_frame_end   (rx_frame_end),
        .receiving      (receiving)
    );

    always #5 econet_clk = ~econet_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected)
            passed++;
        else
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    function automatic logic [15:0] tb_crc(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic [7:0]  b;
        r = c;
        b = d;
        repeat (8) begin
            if (r[0] != b[0])
                r = {1'b0, r[15:1]} ^ 16'h8408;
            else
                r = {1'b0, r[15:1]};
            b = b >> 1;
        end
        return r;
    endfunction

    task automatic send_raw(input logic b);
        @(negedge econet_clk);
        rx = b;
    endtask

    task automatic send_data_bit(input logic b);
        send_raw(b);
        if (b) begin
            tx_ones++;
            if (tx_ones == 5) begin
                send_raw(1'b0);
                tx_ones = 0;
            end
        end else begin
            tx_ones = 0;
        end
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++)
            send_raw(f[i]);
        tx_ones = 0;
    endtask

    task automatic send_idle(input int n);
        repeat (n) send_raw(1'b1);
        tx_ones = 0;
    endtask

    task automatic send_byte_bits(input logic [7:0] v);
        for (int i = 0; i < 8; i++)
            send_data_bit(v[i]);
    endtask

    task automatic applyStimulus(input logic [7:0] v);
        exp_bytes.push_back(v);
        send_byte_bits(v);
    endtask

    // FCS is computed over the intended payload; flip_idx corrupts one sent byte.
    task automatic send_frame(input byte_q_t data, input int flip_idx, input logic [7:0] flip_mask, input bit opening);
        logic [15:0] crc_tx;
        logic [15:0] crc_rx;
        logic [15:0] fcs;
        logic [7:0]  sent;
        crc_tx = 16'hFFFF;
        crc_rx = 16'hFFFF;
        if (opening)
            send_flag();
        foreach (data[i]) begin
            sent   = data[i] ^ ((i == flip_idx) ? flip_mask : 8'h00);
            crc_tx = tb_crc(crc_tx, data[i]);
            crc_rx = tb_crc(crc_rx, sent);
            applyStimulus(sent);
        end
        fcs    = ~crc_tx;
        crc_rx = tb_crc(crc_rx, fcs[7:0]);
        crc_rx = tb_crc(crc_rx, fcs[15:8]);
        applyStimulus(fcs[7:0]);
        applyStimulus(fcs[15:8]);
        exp_fcs.push_back((flip_idx < 0) ? TB_FCS_GOOD : crc_rx);
        send_flag();
    endtask

    task automatic end_scenario(input string tag, input int exp_starts, input int exp_ends);
        checkOutput({tag, "_starts"}, start_cnt, exp_starts);
        checkOutput({tag, "_ends"}, end_cnt, exp_ends);
        checkOutput({tag, "_bytes_left"}, exp_bytes.size(), 0);
        checkOutput({tag, "_fcs_left"}, exp_fcs.size(), 0);
        checkOutput({tag, "_receiving"}, receiving, 1'b0);
        start_cnt = 0;
        end_cnt   = 0;
        exp_bytes.delete();
        exp_fcs.delete();
    endtask

    // Output monitor: compares every strobe against the scoreboard queues.
    always begin
        logic [7:0]  eb;
        logic [15:0] ef;
        @(posedge econet_clk);
        #1;
        if (!reset) begin
            if (rx_byte_ready) begin
                if (await_first) begin
                    checkOutput("start_lead", start_prev, 1'b1);
                    await_first = 1'b0;
                end
                checkOutput("byte_receiving", receiving, 1'b1);
                if (exp_bytes.size() == 0) begin
                    checkOutput("unexpected_byte", exp_bytes.size(), 1);
                end else begin
                    eb = exp_bytes.pop_front();
                    checkOutput("rx_byte", rx_byte, eb);
                end
            end
            if (rx_frame_start) begin
                start_cnt++;
                await_first = 1'b1;
                checkOutput("start_receiving", receiving, 1'b1);
            end
            if (rx_frame_end) begin
                end_cnt++;
                checkOutput("end_receiving", receiving, 1'b1);
                if (exp_fcs.size() == 0) begin
                    checkOutput("unexpected_end", exp_fcs.size(), 1);
                end else begin
                    ef = exp_fcs.pop_front();
                    checkOutput("rx_fcs", rx_fcs, ef);
                    if (ef != TB_FCS_GOOD)
                        checkOutput("fcs_bad", rx_fcs != TB_FCS_GOOD, 1'b1);
                end
            end
            start_prev = rx_frame_start;
        end
    end

    initial begin
        byte_q_t f1, f2, fa, fb, fc;
        logic [7:0] v;
        f1 = '{8'h01, 8'h00, 8'hFE, 8'h00, 8'h80, 8'h99};
        f2 = '{8'h12, 8'hFF, 8'h7E, 8'h34};
        fa = '{8'h01, 8'h02, 8'h03};
        fb = '{8'hC0, 8'hFF, 8'hEE};
        fc = '{8'h7E, 8'h7E};

        reset   = 1'b1;
        rx      = 1'b1;
        inhibit = 1'b0;
        repeat (3) @(negedge econet_clk);
        reset = 1'b0;
        @(posedge econet_clk);
        #1;
        checkOutput("reset_byte", rx_byte, 8'h00);
        checkOutput("reset_fcs", rx_fcs, 16'h0000);
        checkOutput("reset_ready", rx_byte_ready, 1'b0);
        checkOutput("reset_start", rx_frame_start, 1'b0);
        checkOutput("reset_end", rx_frame_end, 1'b0);
        checkOutput("reset_receiving", receiving, 1'b0);
        send_idle(20);
        end_scenario("idle", 0, 0);

        send_frame(f1, -1, 8'h00, 1'b1);
        send_idle(12);
        end_scenario("basic", 1, 1);

        send_frame(f2, -1, 8'h00, 1'b1);
        send_idle(12);
        end_scenario("stuffing", 1, 1);

        send_frame(f2, 3, 8'h08, 1'b1);
        send_idle(12);
        end_scenario("bitflip", 1, 1);

        send_flag();
        applyStimulus(8'hAA);
        applyStimulus(8'h55);
        applyStimulus(8'hC3);
        send_idle(8);
        checkOutput("abort_receiving", receiving, 1'b0);
        send_idle(8);
        send_frame(fa, -1, 8'h00, 1'b1);
        send_idle(12);
        end_scenario("abort", 2, 1);

        send_frame(fb, -1, 8'h00, 1'b1);
        send_frame(fc, -1, 8'h00, 1'b0);
        send_idle(12);
        end_scenario("shared_flag", 2, 2);

        send_flag();
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        v = 8'h33;
        for (int i = 0; i < 4; i++)
            send_data_bit(v[i]);
        checkOutput("inhibit_before", receiving, 1'b1);
        inhibit = 1'b1;
        @(posedge econet_clk);
        #1;
        checkOutput("inhibit_drop", receiving, 1'b0);
        for (int i = 4; i < 8; i++)
            send_data_bit(v[i]);
        send_byte_bits(8'h44);
        send_byte_bits(8'h55);
        send_flag();
        send_idle(12);
        end_scenario("inhibit", 1, 0);
        inhibit = 1'b0;
        send_idle(8);

        send_flag();
        applyStimulus(8'h5A);
        applyStimulus(8'hA5);
        v = 8'h0F;
        for (int i = 0; i < 3; i++)
            send_data_bit(v[i]);
        checkOutput("midreset_before", receiving, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset_receiving", receiving, 1'b0);
        checkOutput("midreset_byte", rx_byte, 8'h00);
        checkOutput("midreset_fcs", rx_fcs, 16'h0000);
        @(negedge econet_clk);
        reset = 1'b0;
        send_idle(12);
        end_scenario("midreset", 1, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
